pc_sequencer: RTL and testbench

//  - Parametrised next-generation program counter; drives the instruction-fetch address stream.
//  - Owns the PC register, sequential increment and fetch valid/ready handshake.
//  - Arbitrates trap, branch/jump redirect, stall and halt/resume.
//  - Sits between the execute/branch unit (redirect, trap) and the fetch stage (fetch_*).

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 22 ++
 rtl/pc_next_sel.sv | 37 +++
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_REDIR,
    SEL_TRAP
  } pc_sel_e;

  // Widest address the mask helper can describe; callers truncate to their width.
  localparam int MAX_ADDR_WIDTH = 128;

  // Mask that clears the instruction-offset bits of an address.
  function automatic logic [MAX_ADDR_WIDTH-1:0] align_mask(input int unsigned offset_bits);
    return {MAX_ADDR_WIDTH{1'b1}} << offset_bits;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-request bus between the PC sequencer (master) and the fetch stage (slave).
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH = 64
) ();

  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [ADDR_WIDTH-1:0] fetch_addr;

  modport master (
    output fetch_valid,
    output fetch_addr,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_addr,
    output fetch_ready
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority select: trap > misaligned redirect > redirect > fire > hold.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 'h100,
  parameter int                    INSTR_BYTES = 4
) (
  input  logic                  trap,
  input  logic                  redirect,
  input  logic                  fire,
  input  logic                  misalign,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output pc_sel_e               sel,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  // Pick the highest-priority source and its target address.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sel     = SEL_HOLD;
    next_pc = pc;
    if (trap || (redirect && misalign)) begin
      sel     = SEL_TRAP;
      next_pc = TRAP_VECTOR;
    end else if (redirect) begin
      sel     = SEL_REDIR;
      next_pc = redirect_addr;
    end else if (fire) begin
      // Natural truncation wraps the top of the address space back to 0.
      sel     = SEL_INC;
      next_pc = pc + ADDR_WIDTH'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, the BOOT/RUN/HALT state and the fetch handshake.
// Optional feature: define PC_MISALIGN_TRAP_EN to turn misaligned redirects into traps
// and expose the misalign_out pulse; otherwise redirect targets are silently aligned.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH_POW = 6,
  localparam int                   ADDR_WIDTH     = 1 << ADDR_WIDTH_POW,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR   = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR    = 'h100,
  parameter int                    INSTR_BYTES    = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  trap_valid,
  input  logic                  halt_req,
  input  logic                  resume_req,
  output logic                  pc_halted,
`ifdef PC_MISALIGN_TRAP_EN
  output logic                  misalign_out,
`endif
  pc_sequencer_if.master        fetch_bus
);

  localparam int unsigned           OFFSET_BITS = $clog2(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK   = ADDR_WIDTH'(align_mask(OFFSET_BITS));

  pc_state_e             state, state_next;
  pc_sel_e               pc_sel;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [ADDR_WIDTH-1:0] redirect_aligned;
  logic                  active, trap_eff, redirect_eff, misaligned, take_trap, fire;

  // Events are only honoured once the sequencer has left BOOT.
  assign active           = (state != BOOT);
  assign trap_eff         = trap_valid & active;
  assign redirect_eff     = redirect_valid & active;
  assign redirect_aligned = redirect_addr & ADDR_MASK;

`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned = redirect_eff & (|(redirect_addr & ~ADDR_MASK));
`else
  assign misaligned = 1'b0;
`endif

  assign take_trap = trap_eff | misaligned;

  // Fetch is offered only in RUN, never during reset or a stall.
  assign fetch_bus.fetch_valid = (state == RUN) & ~stall_in & ~reset;
  assign fetch_bus.fetch_addr  = pc;
  assign fire                  = fetch_bus.fetch_valid & fetch_bus.fetch_ready;

  pc_next_sel #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .trap          (trap_eff),
    .redirect      (redirect_eff),
    .fire          (fire),
    .misalign      (misaligned),
    .pc            (pc),
    .redirect_addr (redirect_aligned),
    .sel           (pc_sel),
    .next_pc       (pc_next)
  );

  // Next-state decode: traps always land in RUN; halt beats resume while running.
  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:    state_next = RUN;
      RUN:     if (!take_trap && halt_req) state_next = HALT;
      HALT:    if (take_trap || resume_req) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // State, PC and status registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= BOOT;
      pc        <= RESET_VECTOR;
      pc_halted <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_out <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      pc_halted <= (state_next == HALT);
      if (pc_sel != SEL_HOLD) pc <= pc_next;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_out <= misaligned;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: stimulus queues the expected address of each
// fetch beat, and a monitor checks every accepted beat against the queue.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam logic [63:0] TRAP = 64'h100;

  logic        clk_in = 1'b0;
  logic        reset, stall_in, redirect_valid, trap_valid, halt_req, resume_req, pc_halted;
  logic [63:0] redirect_addr;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_out;
`endif

  int tests  = 0;
  int failed = 0;
  logic [63:0] exp_q[$];

  pc_sequencer_if #(.ADDR_WIDTH(64)) bus ();

  pc_sequencer dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .trap_valid     (trap_valid),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .pc_halted      (pc_halted),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign_out   (misalign_out),
`endif
    .fetch_bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  // One accepted fetch beat at the given address; ready is dropped again afterwards.
  task automatic beat(input logic [63:0] addr);
    bus.fetch_ready = 1'b1;
    exp_q.push_back(addr);
    @(negedge clk_in);
    check("beat_valid", {63'b0, bus.fetch_valid}, 64'd1);
    cycle();
    bus.fetch_ready = 1'b0;
  endtask

  // Monitor: every accepted beat must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk_in);
      if (bus.fetch_valid && bus.fetch_ready) begin
        check("sb_pending", {63'b0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) check("sb_addr", bus.fetch_addr, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    trap_valid = 1'b0; halt_req = 1'b0; resume_req = 1'b0; bus.fetch_ready = 1'b0;
    cycle();
    cycle();
    @(negedge clk_in);
    check("rst_valid", {63'b0, bus.fetch_valid}, 64'd0);
    check("rst_addr", bus.fetch_addr, 64'h0);
    check("rst_halted", {63'b0, pc_halted}, 64'd0);
    cycle();
    reset = 1'b0;
    bus.fetch_ready = 1'b1;

    // BOOT: no fetch even with ready high, then sequential beats.
    @(negedge clk_in);
    check("boot_valid", {63'b0, bus.fetch_valid}, 64'd0);
    cycle();
    beat(64'h0);
    beat(64'h4);

    // Back-pressure at 0x8 for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("hold_addr", bus.fetch_addr, 64'h8);
      check("hold_valid", {63'b0, bus.fetch_valid}, 64'd1);
      cycle();
    end
    beat(64'h8);
    @(negedge clk_in);
    check("adv_addr", bus.fetch_addr, 64'hC);
    cycle();

    // Redirect under stall.
    redirect_valid = 1'b1; redirect_addr = 64'h40; stall_in = 1'b1; bus.fetch_ready = 1'b1;
    @(negedge clk_in);
    check("stall_valid", {63'b0, bus.fetch_valid}, 64'd0);
    cycle();
    redirect_valid = 1'b0; bus.fetch_ready = 1'b0;
    @(negedge clk_in);
    check("redir_addr", bus.fetch_addr, 64'h40);
    check("redir_stall_valid", {63'b0, bus.fetch_valid}, 64'd0);
    cycle();
    stall_in = 1'b0;
    @(negedge clk_in);
    check("stall_clear_valid", {63'b0, bus.fetch_valid}, 64'd1);
    cycle();
    beat(64'h40);

    // Trap beats a coincident redirect.
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_addr = 64'h80;
    cycle();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    @(negedge clk_in);
    check("trap_addr", bus.fetch_addr, TRAP);
    cycle();
    beat(TRAP);

    // Halt coincident with a beat at 0x10, then resume.
    redirect_valid = 1'b1; redirect_addr = 64'h10;
    cycle();
    redirect_valid = 1'b0;
    halt_req = 1'b1;
    beat(64'h10);
    @(negedge clk_in);
    check("halt_flag", {63'b0, pc_halted}, 64'd1);
    check("halt_valid", {63'b0, bus.fetch_valid}, 64'd0);
    check("halt_addr", bus.fetch_addr, 64'h14);
    cycle();
    halt_req = 1'b0;
    resume_req = 1'b1;
    cycle();
    resume_req = 1'b0;
    @(negedge clk_in);
    check("resume_flag", {63'b0, pc_halted}, 64'd0);
    cycle();
    beat(64'h14);

    // Halt without a beat, redirect while halted, then leave HALT through a trap.
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 64'h20;
    cycle();
    redirect_valid = 1'b0;
    @(negedge clk_in);
    check("halt_redir_addr", bus.fetch_addr, 64'h20);
    check("halt_redir_flag", {63'b0, pc_halted}, 64'd1);
    trap_valid = 1'b1;
    cycle();
    trap_valid = 1'b0;
    @(negedge clk_in);
    check("halt_trap_addr", bus.fetch_addr, TRAP);
    check("halt_trap_flag", {63'b0, pc_halted}, 64'd0);
    check("halt_trap_valid", {63'b0, bus.fetch_valid}, 64'd1);
    cycle();

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_addr = 64'h42;
    cycle();
    redirect_valid = 1'b0;
    @(negedge clk_in);
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign_addr", bus.fetch_addr, TRAP);
    check("misalign_pulse", {63'b0, misalign_out}, 64'd1);
    cycle();
    @(negedge clk_in);
    check("misalign_clear", {63'b0, misalign_out}, 64'd0);
`else
    check("misalign_addr", bus.fetch_addr, 64'h40);
`endif
    cycle();

    // Wrap from the top of the address space.
    redirect_valid = 1'b1; redirect_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    beat(64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk_in);
    check("wrap_addr", bus.fetch_addr, 64'h0);
    cycle();
    beat(64'h0);

    // Reset in the middle of a fetch beat abandons it.
    reset = 1'b1; bus.fetch_ready = 1'b1;
    @(negedge clk_in);
    check("midrst_valid", {63'b0, bus.fetch_valid}, 64'd0);
    cycle();
    bus.fetch_ready = 1'b0;
    @(negedge clk_in);
    check("midrst_addr", bus.fetch_addr, 64'h0);
    check("midrst_halted", {63'b0, pc_halted}, 64'd0);
    cycle();
    reset = 1'b0;

    @(negedge clk_in);
    check("sb_drained", exp_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
